// File: rtl/instr_encoder.sv
// RV32 instruction assembler: packs op/rd/rs1/rs2/imm into R-type or ADDI words and queues them in a DEPTH-entry FIFO.
// Latency: a word accepted on edge N is at the FIFO head (o_code_valid=1) right after that edge; o_err pulses the cycle after an illegal accept.
// Backpressure: o_in_ready = FIFO not full, independent of i_code_ready (no full-FIFO bypass); pops on o_code_valid && i_code_ready.
// Optional feature macro: INSTR_ENCODER_MUL_EN (op 2 encodes MUL when defined, otherwise op 2 is illegal).
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [3:0]    i_op,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic [11:0]   i_imm,
  output logic [31:0]   o_code,
  output logic          o_code_valid,
  input  logic          i_code_ready,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [6:0]    OPC_R   = 7'b0110011;
  localparam logic [6:0]    OPC_I   = 7'b0010011;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_ADDI = 4'd11;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [6:0]    w_funct7;
  logic [2:0]    w_funct3;
  logic          w_itype;
  logic          w_legal;
  logic [31:0]   w_word;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  // Decode the op select into funct fields, format and legality, then pack the word.
  always_comb begin
    w_funct7 = 7'b0000000;
    w_funct3 = 3'b000;
    w_itype  = 1'b0;
    w_legal  = 1'b1;
    case (i_op)
      OP_ADD:  w_funct3 = 3'b000;
      OP_SUB:  w_funct7 = 7'b0100000;
`ifdef INSTR_ENCODER_MUL_EN
      OP_MUL:  w_funct7 = 7'b0000001;
`else
      OP_MUL:  w_legal  = 1'b0;
`endif
      OP_AND:  w_funct3 = 3'b111;
      OP_OR:   w_funct3 = 3'b110;
      OP_XOR:  w_funct3 = 3'b100;
      OP_SLT:  w_funct3 = 3'b010;
      OP_SLTU: w_funct3 = 3'b011;
      OP_SRA: begin
        w_funct7 = 7'b0100000;
        w_funct3 = 3'b101;
      end
      OP_SRL:  w_funct3 = 3'b101;
      OP_SLL:  w_funct3 = 3'b001;
      OP_ADDI: w_itype  = 1'b1;
      default: w_legal  = 1'b0;
    endcase
    if (w_itype) begin
      w_word = {i_imm, i_rs1, 3'b000, i_rd, OPC_I};
    end else begin
      w_word = {w_funct7, i_rs2, i_rs1, w_funct3, i_rd, OPC_R};
    end
  end

  // Handshake qualifiers; illegal ops complete the handshake but never write the FIFO.
  always_comb begin
    w_in_ready = (r_count != FULL);
    w_accept   = i_in_valid && w_in_ready;
    w_push     = w_accept && w_legal;
    w_pop      = (r_count != '0) && i_code_ready;
  end

  // FIFO storage, pointers and occupancy; reset discards everything, storage cleared so o_code reads 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle error pulse following an accepted illegal op.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
    end
  end

  // Output drive: head entry and status flags straight from state.
  always_comb begin
    o_code       = r_mem[r_rd_ptr];
    o_code_valid = (r_count != '0);
    o_in_ready   = w_in_ready;
    o_count      = r_count;
    o_err        = r_err;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, FIFO fill/drain, illegal ops, mid-stream reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected words are hand-computed constants.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;
  logic [31:0] code;
  logic        code_valid;
  logic        code_ready;
  logic [2:0]  count;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder #(.DEPTH(4), .CW(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_op         (op),
    .i_rd         (rd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .i_imm        (imm),
    .o_code       (code),
    .o_code_valid (code_valid),
    .i_code_ready (code_ready),
    .o_count      (count),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [11:0] im);
    op  = o;
    rd  = d;
    rs1 = s1;
    rs2 = s2;
    imm = im;
  endtask

  // One-cycle push of a field set.
  task automatic push(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [11:0] im);
    set_fields(o, d, s1, s2, im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    code_ready = 1'b1;
    step();
    code_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    code_ready = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", code, 32'h0);
    rst = 1'b0;
    step();

    // ADD then SUB, each visible one cycle after accept
    push(4'd0, 5'd0, 5'd2, 5'd4, 12'd0);
    check("add_valid", 32'(code_valid), 32'd1);
    check("add_code", code, 32'h00410033);
    check("add_count", 32'(count), 32'd1);
    pop();
    check("add_popped", 32'(count), 32'd0);
    push(4'd1, 5'd0, 5'd2, 5'd4, 12'd0);
    check("sub_code", code, 32'h40410033);
    pop();

    // ADDI: rs2 must not leak into the word
    push(4'd11, 5'd0, 5'd7, 5'h1F, 12'd3);
    check("addi_code", code, 32'h00338013);
    pop();
    push(4'd11, 5'd1, 5'd0, 5'd9, 12'hFFF);
    check("addi_maxim", code, 32'hFFF00093);
    pop();
    push(4'd3, 5'd1, 5'd3, 5'd5, 12'hABC);
    check("and_code", code, 32'h0051F0B3);
    pop();
    push(4'd10, 5'd4, 5'd0, 5'd1, 12'd0);
    check("sll_code", code, 32'h00101233);
    pop();

    // MUL depends on build option
    push(4'd2, 5'd0, 5'd2, 5'd4, 12'd0);
`ifdef INSTR_ENCODER_MUL_EN
    check("mul_code", code, 32'h02410033);
    check("mul_count", 32'(count), 32'd1);
    check("mul_err", 32'(err), 32'd0);
    pop();
`else
    check("mul_count", 32'(count), 32'd0);
    check("mul_err", 32'(err), 32'd1);
    step();
    check("mul_err_clear", 32'(err), 32'd0);
`endif
    check("mul_empty", 32'(count), 32'd0);

    // Fill with consumer stalled
    push(4'd4, 5'd1, 5'd2, 5'd3, 12'd0);   // OR   -> 003160B3
    push(4'd5, 5'd2, 5'd3, 5'd4, 12'd0);   // XOR  -> 0041C133
    push(4'd6, 5'd3, 5'd4, 5'd5, 12'd0);   // SLT  -> 005221B3
    push(4'd8, 5'd31, 5'd31, 5'd31, 12'd0); // SRA -> 41FFDFB3
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", code, 32'h003160B3);
    // Fifth field set (SLTU -> 007332B3) held off while full
    set_fields(4'd7, 5'd5, 5'd6, 5'd7, 12'd0);
    in_valid = 1'b1;
    step();
    check("held_count", 32'(count), 32'd4);
    check("held_head", code, 32'h003160B3);
    code_ready = 1'b1;
    step();
    check("pop_only_count", 32'(count), 32'd3);
    check("pop_only_head", code, 32'h0041C133);
    check("pop_only_rdy", 32'(in_ready), 32'd1);
    step();
    check("pushpop1_count", 32'(count), 32'd3);
    check("pushpop1_head", code, 32'h005221B3);
    set_fields(4'd9, 5'd0, 5'd1, 5'd2, 12'd0); // SRL -> 0020D033
    step();
    check("pushpop2_count", 32'(count), 32'd3);
    check("pushpop2_head", code, 32'h41FFDFB3);
    in_valid = 1'b0;
    step();
    check("drain1_head", code, 32'h007332B3);
    check("drain1_count", 32'(count), 32'd2);
    step();
    check("drain2_head", code, 32'h0020D033);
    step();
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(code_valid), 32'd0);
    code_ready = 1'b0;

    // Illegal op 13: single pulse, nothing queued
    push(4'd13, 5'd1, 5'd1, 5'd1, 12'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_count", 32'(count), 32'd0);
    step();
    check("ill_err_once", 32'(err), 32'd0);
    push(4'd0, 5'd0, 5'd2, 5'd4, 12'd0);
    check("after_ill_code", code, 32'h00410033);
    pop();

    // Back-to-back illegal ops give back-to-back pulses
    set_fields(4'd14, 5'd0, 5'd0, 5'd0, 12'd0);
    in_valid = 1'b1;
    step();
    check("b2b_err1", 32'(err), 32'd1);
    set_fields(4'd15, 5'd0, 5'd0, 5'd0, 12'd0);
    step();
    check("b2b_err2", 32'(err), 32'd1);
    in_valid = 1'b0;
    step();
    check("b2b_err_end", 32'(err), 32'd0);
    check("b2b_count", 32'(count), 32'd0);

    // Mid-stream reset with three words queued
    push(4'd4, 5'd1, 5'd2, 5'd3, 12'd0);
    push(4'd5, 5'd2, 5'd3, 5'd4, 12'd0);
    push(4'd6, 5'd3, 5'd4, 5'd5, 12'd0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(code_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_code", code, 32'h0);
    step();
    rst = 1'b0;
    step();
    push(4'd11, 5'd0, 5'd7, 5'd0, 12'd3);
    check("post_rst_code", code, 32'h00338013);
    check("post_rst_count", 32'(count), 32'd1);
    pop();
    check("post_rst_empty", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
